// File: rtl/eject_scheduler.sv
// ---------------------------------------------------------------------------------------------
// eject_scheduler
//
// Per-cycle ejection arbiter for the router's local port. Among the input channels whose flit
// is destined to this node, at most one is granted each cycle using a round-robin pointer.
// The grant is purely combinational from eject_req and the registered pointer/credit state,
// so the winner's flit is captured by the PE on the same clock edge. Channels that request
// but are not granted are reported on defl_vector so the permutation stage deflects them.
//
// PE-side buffer space is tracked with a credit counter. A grant consumes one credit and a
// credit_ret pulse returns one. A return while the counter is already full is a protocol
// error and sets the sticky credit_err flag.
//
// Optional build macro:
//   EJECT_STATS_EN  adds saturating 16-bit eject_count / defl_count statistics outputs.
//                   Grant and credit behaviour is identical with or without it.
//
// Ports:
//   clk          in   rising-edge system clock
//   reset        in   asynchronous, active-high reset
//   eject_req    in   [NUM_CHANNEL]  bit i set = channel i holds a flit for the local node
//   credit_ret   in   PE freed one buffer slot this cycle
//   localVector  out  [NUM_CHANNEL]  one-hot (or zero) select for the ejector mux
//   eject_valid  out  a flit is ejected at this clock edge (|localVector)
//   defl_vector  out  [NUM_CHANNEL]  requesting channels that lost arbitration
//   credit_cnt   out  [CREDIT_WIDTH] credits currently available
//   credit_err   out  sticky; credit returned while counter already full
//   eject_count  out  [16] (EJECT_STATS_EN only) granted flits, saturating
//   defl_count   out  [16] (EJECT_STATS_EN only) total deflected flits, saturating
// ---------------------------------------------------------------------------------------------

module eject_scheduler #(
  parameter int NUM_CHANNEL  = 5,
  parameter int NUM_CREDIT   = 4,
  parameter int CREDIT_WIDTH = 3,
  parameter int PTR_WIDTH    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNEL-1:0]  eject_req,
  input  logic                    credit_ret,
  output logic [NUM_CHANNEL-1:0]  localVector,
  output logic                    eject_valid,
  output logic [NUM_CHANNEL-1:0]  defl_vector,
  output logic [CREDIT_WIDTH-1:0] credit_cnt,
  output logic                    credit_err
`ifdef EJECT_STATS_EN
  ,
  output logic [15:0]             eject_count,
  output logic [15:0]             defl_count
`endif
);

  localparam logic [CREDIT_WIDTH-1:0] CreditFull = CREDIT_WIDTH'(NUM_CREDIT);
  localparam logic [PTR_WIDTH-1:0]    LastChan   = PTR_WIDTH'(NUM_CHANNEL - 1);
  localparam logic [PTR_WIDTH:0]      NumChanExt = (PTR_WIDTH + 1)'(NUM_CHANNEL);

  // Registered state
  logic [PTR_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic                    err_q, err_d;

  // Combinational grant
  logic [NUM_CHANNEL-1:0] grant;
  logic [PTR_WIDTH-1:0]   grant_idx;
  logic                   grant_found;
  logic [PTR_WIDTH:0]     scan_sum;
  logic [PTR_WIDTH-1:0]   scan_idx;

  // ---------------------------------------------------------------------------
  // Round-robin scan: visit rr_ptr, rr_ptr+1, ... modulo NUM_CHANNEL and take
  // the first requester. scan_sum is one bit wider so rr_ptr+k cannot overflow
  // before the wrap is applied. Grant is forced off while reset is asserted so
  // no flit is captured during reset, and off when no credit is available.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_sum    = '0;
    scan_idx    = '0;
    if (!reset && (credit_q != '0)) begin
      for (int k = 0; k < NUM_CHANNEL; k++) begin
        scan_sum = {1'b0, rr_ptr_q} + (PTR_WIDTH + 1)'(k);
        if (scan_sum >= NumChanExt) begin
          scan_sum = scan_sum - NumChanExt;
        end
        scan_idx = scan_sum[PTR_WIDTH-1:0];
        if (!grant_found && eject_req[scan_idx]) begin
          grant_found      = 1'b1;
          grant[scan_idx]  = 1'b1;
          grant_idx        = scan_idx;
        end
      end
    end
  end

  assign localVector = grant;
  assign eject_valid = grant_found;
  // Losers are deflected; with no credit every requester loses.
  assign defl_vector = reset ? '0 : (eject_req & ~grant);
  assign credit_cnt  = credit_q;
  assign credit_err  = err_q;

  // ---------------------------------------------------------------------------
  // Pointer advances past the winner; idle cycles leave it where it is.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_found) begin
      rr_ptr_d = (grant_idx == LastChan) ? '0 : grant_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Credit accounting. A grant and a return in the same cycle cancel. A return
  // with the counter full and no grant would overflow the PE buffer model, so
  // the count saturates and the error is latched until reset. A grant is only
  // possible with credit_q != 0, so the decrement cannot underflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    unique case ({grant_found, credit_ret})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CreditFull) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + 1'b1;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      credit_q <= CreditFull;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

`ifdef EJECT_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics. The deflection sum is formed one bit wider than the
  // counter so the carry out can be detected and clamped to all-ones.
  // ---------------------------------------------------------------------------
  logic [15:0] eject_count_q, eject_count_d;
  logic [15:0] defl_count_q, defl_count_d;
  logic [16:0] defl_sum;
  logic [16:0] defl_pop;

  always_comb begin
    defl_pop = '0;
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      defl_pop = defl_pop + 17'(defl_vector[i]);
    end
    defl_sum = {1'b0, defl_count_q} + defl_pop;
    defl_count_d = defl_sum[16] ? 16'hFFFF : defl_sum[15:0];

    eject_count_d = eject_count_q;
    if (eject_valid && (eject_count_q != 16'hFFFF)) begin
      eject_count_d = eject_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eject_count_q <= '0;
      defl_count_q  <= '0;
    end else begin
      eject_count_q <= eject_count_d;
      defl_count_q  <= defl_count_d;
    end
  end

  assign eject_count = eject_count_q;
  assign defl_count  = defl_count_q;
`endif

endmodule

// File: tb/tb_eject_scheduler.sv
module tb_eject_scheduler;

  localparam int NCH  = 5;
  localparam int NCR  = 4;

  logic       clk;
  logic       reset;
  logic [4:0] eject_req;
  logic       credit_ret;
  logic [4:0] localVector;
  logic       eject_valid;
  logic [4:0] defl_vector;
  logic [2:0] credit_cnt;
  logic       credit_err;
`ifdef EJECT_STATS_EN
  logic [15:0] eject_count;
  logic [15:0] defl_count;
`endif

  eject_scheduler #(
    .NUM_CHANNEL  (5),
    .NUM_CREDIT   (4),
    .CREDIT_WIDTH (3),
    .PTR_WIDTH    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .eject_req   (eject_req),
    .credit_ret  (credit_ret),
    .localVector (localVector),
    .eject_valid (eject_valid),
    .defl_vector (defl_vector),
    .credit_cnt  (credit_cnt),
    .credit_err  (credit_err)
`ifdef EJECT_STATS_EN
    ,
    .eject_count (eject_count),
    .defl_count  (defl_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  task automatic cmp(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_rr  = 0;
  int m_cnt = NCR;
  bit m_err = 1'b0;
  int m_ej  = 0;
  int m_df  = 0;

  // Winner channel by round-robin rule, or -1 when nothing is granted.
  function automatic int pick(input logic [4:0] req, input int rr, input int cnt);
    if (cnt == 0) return -1;
    for (int off = 0; off < NCH; off++) begin
      int ch;
      ch = (rr + off) % NCH;
      if (req[ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [4:0] onehot(input int ch);
    logic [4:0] v;
    v = '0;
    if (ch >= 0) v[ch] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rr  <= 0;
      m_cnt <= NCR;
      m_err <= 1'b0;
      m_ej  <= 0;
      m_df  <= 0;
    end else begin
      m_rr  <= (pick(eject_req, m_rr, m_cnt) >= 0) ? (pick(eject_req, m_rr, m_cnt) + 1) % NCH
                                                   : m_rr;
      m_cnt <= ((m_cnt - ((pick(eject_req, m_rr, m_cnt) >= 0) ? 1 : 0) + int'(credit_ret)) > NCR)
               ? NCR : (m_cnt - ((pick(eject_req, m_rr, m_cnt) >= 0) ? 1 : 0) + int'(credit_ret));
      m_err <= m_err | (credit_ret && (m_cnt == NCR) && (pick(eject_req, m_rr, m_cnt) < 0));
      m_ej  <= ((pick(eject_req, m_rr, m_cnt) >= 0) && (m_ej < 65535)) ? m_ej + 1 : m_ej;
      m_df  <= (m_df + $countones(eject_req & ~onehot(pick(eject_req, m_rr, m_cnt))) > 65535)
               ? 65535 : m_df + $countones(eject_req & ~onehot(pick(eject_req, m_rr, m_cnt)));
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] exp_lv;
      logic [4:0] exp_defl;
      exp_lv   = reset ? 5'b0 : onehot(pick(eject_req, m_rr, m_cnt));
      exp_defl = reset ? 5'b0 : (eject_req & ~exp_lv);
      cmp("localVector", int'(localVector), int'(exp_lv));
      cmp("eject_valid", int'(eject_valid), int'(|exp_lv));
      cmp("defl_vector", int'(defl_vector), int'(exp_defl));
      cmp("credit_cnt",  int'(credit_cnt),  m_cnt);
      cmp("credit_err",  int'(credit_err),  int'(m_err));
      cmp("onehot0",     int'($onehot0(localVector)), 1);
`ifdef EJECT_STATS_EN
      cmp("eject_count", int'(eject_count), m_ej);
      cmp("defl_count",  int'(defl_count),  m_df);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive just after a rising edge; return mid-cycle, before the falling edge.
  task automatic drive(input logic [4:0] req, input logic ret);
    @(posedge clk);
    #1;
    eject_req  = req;
    credit_ret = ret;
    #3;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    eject_req  = '0;
    credit_ret = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #3;
  endtask

  initial begin
    logic [4:0] r;
    reset      = 1'b1;
    eject_req  = '0;
    credit_ret = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    #3;
    cmp("reset_cnt", int'(credit_cnt), 4);
    cmp("reset_err", int'(credit_err), 0);
    cmp("reset_lv",  int'(localVector), 0);

    // Single request after reset
    drive(5'b00100, 1'b0);
    cmp("t1_lv",    int'(localVector), 5'b00100);
    cmp("t1_valid", int'(eject_valid), 1);
    drive(5'b00000, 1'b0);
    cmp("t1_cnt",   int'(credit_cnt), 3);
    drive(5'b11111, 1'b0);
    cmp("t1_rr3",   int'(localVector), 5'b01000);

    // Full request held with a return every cycle: rotating grants, credits steady
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(5'b11111, 1'b1);
      cmp("t2_lv",  int'(localVector), 1 << i);
      cmp("t2_cnt", int'(credit_cnt), 4);
    end

    // Exhaust credits, no bypass on return
    do_reset();
    for (int i = 0; i < 4; i++) drive(5'b11111, 1'b0);
    drive(5'b00011, 1'b0);
    cmp("t3_cnt0", int'(credit_cnt), 0);
    cmp("t3_lv0",  int'(localVector), 0);
    cmp("t3_defl", int'(defl_vector), 5'b00011);
    drive(5'b00011, 1'b1);
    cmp("t3_nobypass", int'(localVector), 0);
    drive(5'b00011, 1'b0);
    cmp("t3_resume", int'(localVector), 5'b00001);

    // Wrap from pointer 4 to channel 0
    do_reset();
    drive(5'b01000, 1'b0);
    drive(5'b00011, 1'b0);
    cmp("t4_lv",   int'(localVector), 5'b00001);
    cmp("t4_defl", int'(defl_vector), 5'b00010);
    drive(5'b00011, 1'b0);
    cmp("t4_rr1",  int'(localVector), 5'b00010);

    // Return while full sets sticky error; async reset mid-grant
    do_reset();
    drive(5'b00000, 1'b1);
    drive(5'b00000, 1'b0);
    cmp("t5_cnt", int'(credit_cnt), 4);
    cmp("t5_err", int'(credit_err), 1);
    drive(5'b00000, 1'b0);
    cmp("t5_sticky", int'(credit_err), 1);
    drive(5'b00001, 1'b0);
    cmp("t5_grant", int'(localVector), 5'b00001);
    #2 reset = 1'b1;
    #1;
    cmp("t5_rst_lv",    int'(localVector), 0);
    cmp("t5_rst_valid", int'(eject_valid), 0);
    cmp("t5_rst_defl",  int'(defl_vector), 0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    eject_req = '0;
    #3;
    cmp("t5_rst_cnt", int'(credit_cnt), 4);
    cmp("t5_rst_err", int'(credit_err), 0);

`ifdef EJECT_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) drive(5'b00111, 1'b1);
    drive(5'b00000, 1'b0);
    cmp("t6_ej", int'(eject_count), 3);
    cmp("t6_df", int'(defl_count), 6);
`endif

    // Randomised traffic with occasional asynchronous resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        cmp("rnd_rst_lv", int'(localVector), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
      end else begin
        r = 5'($urandom);
        drive(r, ($urandom_range(0, 9) < 4));
      end
    end

    drive(5'b00000, 1'b0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
